// File: rtl/pipe_stage_elastic.sv
// Two-entry elastic pipeline stage (main + skid register) carrying write-back payload.
// Head entry is always held in the main register, so every output except in_ready comes straight from a flop.
module pipe_stage_elastic #(
   parameter int CTRL_W = 2,
   parameter int DATA_W = 32,
   parameter int RD_W   = 5
) (
   input  logic              reloj,
   input  logic              reset_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_do,
   input  logic [DATA_W-1:0] in_dir,
   input  logic [RD_W-1:0]   in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_do,
   output logic [DATA_W-1:0] out_dir,
   output logic [RD_W-1:0]   out_rd,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_r;
   logic              out_valid_r;
   logic [CTRL_W-1:0] main_ctrl_r;
   logic [DATA_W-1:0] main_do_r;
   logic [DATA_W-1:0] main_dir_r;
   logic [RD_W-1:0]   main_rd_r;
   logic [CTRL_W-1:0] skid_ctrl_r;
   logic [DATA_W-1:0] skid_do_r;
   logic [DATA_W-1:0] skid_dir_r;
   logic [RD_W-1:0]   skid_rd_r;
   logic              in_ready_s;
   logic              push_s;
   logic              pop_s;

   // Handshake decode; ready depends only on state, flush and reset, never on out_ready.
   always_comb begin
      in_ready_s = reset_n & ~flush & (state_r != FULL);
      push_s     = in_valid & in_ready_s;
      pop_s      = out_valid_r & out_ready;
   end

   // Occupancy FSM and payload registers; a bubble clears the control field so no write-back leaks out.
   always_ff @(posedge reloj or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= EMPTY;
         out_valid_r <= 1'b0;
         main_ctrl_r <= {CTRL_W{1'b0}};
         main_do_r   <= {DATA_W{1'b0}};
         main_dir_r  <= {DATA_W{1'b0}};
         main_rd_r   <= {RD_W{1'b0}};
         skid_ctrl_r <= {CTRL_W{1'b0}};
         skid_do_r   <= {DATA_W{1'b0}};
         skid_dir_r  <= {DATA_W{1'b0}};
         skid_rd_r   <= {RD_W{1'b0}};
      end else if (flush) begin
         state_r     <= EMPTY;
         out_valid_r <= 1'b0;
         main_ctrl_r <= {CTRL_W{1'b0}};
         skid_ctrl_r <= {CTRL_W{1'b0}};
      end else begin
         case (state_r)
            EMPTY: begin
               if (push_s) begin
                  main_ctrl_r <= in_ctrl;
                  main_do_r   <= in_do;
                  main_dir_r  <= in_dir;
                  main_rd_r   <= in_rd;
                  out_valid_r <= 1'b1;
                  state_r     <= ONE;
               end
            end
            ONE: begin
               if (push_s && pop_s) begin
                  main_ctrl_r <= in_ctrl;
                  main_do_r   <= in_do;
                  main_dir_r  <= in_dir;
                  main_rd_r   <= in_rd;
               end else if (push_s) begin
                  skid_ctrl_r <= in_ctrl;
                  skid_do_r   <= in_do;
                  skid_dir_r  <= in_dir;
                  skid_rd_r   <= in_rd;
                  state_r     <= FULL;
               end else if (pop_s) begin
                  main_ctrl_r <= {CTRL_W{1'b0}};
                  out_valid_r <= 1'b0;
                  state_r     <= EMPTY;
               end
            end
            FULL: begin
               if (pop_s) begin
                  main_ctrl_r <= skid_ctrl_r;
                  main_do_r   <= skid_do_r;
                  main_dir_r  <= skid_dir_r;
                  main_rd_r   <= skid_rd_r;
                  state_r     <= ONE;
               end
            end
            default: begin
               main_ctrl_r <= {CTRL_W{1'b0}};
               out_valid_r <= 1'b0;
               state_r     <= EMPTY;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_ctrl  = main_ctrl_r;
   assign out_do    = main_do_r;
   assign out_dir   = main_dir_r;
   assign out_rd    = main_rd_r;
   assign occupancy = state_r;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: a queue model tracks held entries and a
// negedge monitor compares handshake, occupancy and head payload every cycle.
module tb_pipe_stage_elastic;

   logic        reloj = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_ctrl;
   logic [31:0] in_do;
   logic [31:0] in_dir;
   logic [4:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_ctrl;
   logic [31:0] out_do;
   logic [31:0] out_dir;
   logic [4:0]  out_rd;
   logic [1:0]  occupancy;

   int checks   = 0;
   int failures = 0;
   logic [70:0] model_q[$];

   pipe_stage_elastic #(.CTRL_W(2), .DATA_W(32), .RD_W(5)) dut (
      .reloj(reloj), .reset_n(reset_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_ctrl(in_ctrl), .in_do(in_do), .in_dir(in_dir), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_ctrl(out_ctrl), .out_do(out_do), .out_dir(out_dir), .out_rd(out_rd),
      .occupancy(occupancy)
   );

   always #5 reloj = ~reloj;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge reloj);
      #2;
   endtask

   task automatic offer(input logic v, input logic [1:0] c, input logic [31:0] d,
                        input logic [31:0] a, input logic [4:0] r);
      in_valid = v; in_ctrl = c; in_do = d; in_dir = a; in_rd = r;
   endtask

   // Reference model: a FIFO of at most two accepted entries, emptied by flush or reset.
   always @(negedge reloj) begin
      logic exp_ready;
      if (!reset_n) begin
         chk("rst_occupancy", occupancy, 2'd0);
         chk("rst_out_valid", out_valid, 1'b0);
         chk("rst_in_ready", in_ready, 1'b0);
         chk("rst_out_ctrl", out_ctrl, 2'd0);
         model_q.delete();
      end else begin
         exp_ready = (model_q.size() < 2) && !flush;
         chk("in_ready", in_ready, exp_ready);
         chk("occupancy", occupancy, model_q.size());
         chk("out_valid", out_valid, model_q.size() > 0);
         if (model_q.size() == 0)
            chk("bubble_ctrl", out_ctrl, 2'd0);
         else
            chk("head_payload", {out_ctrl, out_do, out_dir, out_rd}, model_q[0]);
         if (flush) begin
            model_q.delete();
         end else begin
            if (out_ready && model_q.size() > 0) void'(model_q.pop_front());
            if (in_valid && exp_ready) model_q.push_back({in_ctrl, in_do, in_dir, in_rd});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
      offer(1'b0, 2'd0, 32'd0, 32'd0, 5'd0);
      #1;
      chk("async_rst_out_valid", out_valid, 1'b0);
      chk("async_rst_in_ready", in_ready, 1'b0);
      tick(); tick();
      reset_n = 1'b1;
      #1;
      chk("post_rst_in_ready", in_ready, 1'b1);
      chk("post_rst_occupancy", occupancy, 2'd0);

      // Single entry, one-cycle latency.
      tick();
      out_ready = 1'b1;
      offer(1'b1, 2'b01, 32'hDEADBEEF, 32'h00000010, 5'd7);
      tick();
      offer(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
      #1;
      chk("lat_out_valid", out_valid, 1'b1);
      chk("lat_out_ctrl", out_ctrl, 2'b01);
      chk("lat_out_do", out_do, 32'hDEADBEEF);
      chk("lat_out_dir", out_dir, 32'h00000010);
      chk("lat_out_rd", out_rd, 5'd7);
      chk("lat_occupancy", occupancy, 2'd1);
      tick(); tick();

      // Backpressure: fill, refuse third entry, then drain in order.
      out_ready = 1'b0;
      offer(1'b1, 2'b10, 32'hA0A0A0A0, 32'h00000100, 5'd1);
      tick();
      offer(1'b1, 2'b11, 32'hB0B0B0B0, 32'h00000200, 5'd2);
      tick();
      offer(1'b1, 2'b01, 32'hC0C0C0C0, 32'h00000300, 5'd3);
      #1;
      chk("full_occupancy", occupancy, 2'd2);
      chk("full_in_ready", in_ready, 1'b0);
      tick();
      #1;
      chk("full_hold_occupancy", occupancy, 2'd2);
      chk("full_hold_rd", out_rd, 5'd1);
      out_ready = 1'b1;
      #1;
      chk("drain_a_rd", out_rd, 5'd1);
      tick();
      chk("drain_b_rd", out_rd, 5'd2);
      tick();
      offer(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
      #1;
      chk("drain_c_rd", out_rd, 5'd3);
      tick(); tick();
      #1;
      chk("drained_occupancy", occupancy, 2'd0);

      // Full-rate stream keeps exactly one entry in flight.
      for (int i = 0; i < 16; i++) begin
         offer(1'b1, 2'($urandom), $urandom, $urandom, 5'(i));
         tick();
         #1;
         chk("stream_rd", out_rd, 5'(i));
         chk("stream_occupancy", occupancy, 2'd1);
         #1;
      end
      offer(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
      tick(); tick();

      // Flush overrides a simultaneous push while full.
      out_ready = 1'b0;
      offer(1'b1, 2'b11, 32'h11111111, 32'h22222222, 5'd9);
      tick(); tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      offer(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
      #1;
      chk("flush_occupancy", occupancy, 2'd0);
      chk("flush_out_valid", out_valid, 1'b0);
      chk("flush_out_ctrl", out_ctrl, 2'd0);
      tick();

      // Asynchronous reset while full.
      offer(1'b1, 2'b11, 32'h33333333, 32'h44444444, 5'd12);
      tick(); tick();
      offer(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
      #1;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_in_ready", in_ready, 1'b0);
      chk("mid_rst_occupancy", occupancy, 2'd0);
      tick();
      reset_n = 1'b1;
      #1;
      chk("rel_in_ready", in_ready, 1'b1);
      chk("rel_occupancy", occupancy, 2'd0);
      tick();

      // Random traffic with occasional flush.
      for (int i = 0; i < 10000; i++) begin
         offer(1'($urandom), 2'($urandom), $urandom, $urandom, 5'($urandom));
         out_ready = 1'($urandom);
         flush = ($urandom_range(63) == 0);
         tick();
      end
      flush = 1'b0;
      out_ready = 1'b1;
      offer(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
      tick(); tick(); tick();
      #4;
      chk("final_model_empty", model_q.size(), 0);
      chk("final_occupancy", occupancy, 2'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage_elastic.md
PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 Parameter CTRL_W, default 2, width of the write-back control field (bit CTRL_W-1 = DIR_WB select, bit CTRL_W-2 = REG_WR).
REQ-002 Parameter DATA_W, default 32, width of each of the two data payload fields (memory read data, ALU address/result).
REQ-003 Parameter RD_W, default 5, width of the destination-register index field.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 reloj  input  1  clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 flush  input  1  synchronous kill of all held entries.
REQ-008 in_valid  input  1  upstream entry present.
REQ-009 in_ready  output  1  stage can accept an entry this cycle.
REQ-010 in_ctrl  input  CTRL_W  write-back control bits.
REQ-011 in_do  input  DATA_W  data-memory read data.
REQ-012 in_dir  input  DATA_W  data-memory address / ALU result.
REQ-013 in_rd  input  RD_W  destination register index.
REQ-014 out_valid  output  1  head entry present downstream.
REQ-015 out_ready  input  1  downstream consumes head entry this cycle.
REQ-016 out_ctrl, out_do, out_dir, out_rd  output  CTRL_W/DATA_W/DATA_W/RD_W  head-entry fields.
REQ-017 occupancy  output  2  number of held entries (0..2).

Function
REQ-018 The block SHALL be a 2-entry elastic stage (main register + skid register); payload = {ctrl, do, dir, rd}.
REQ-019 Transfer-in SHALL occur when in_valid & in_ready at a rising edge; transfer-out when out_valid & out_ready.
REQ-020 State machine SHALL have states EMPTY (occ 0), ONE (occ 1), FULL (occ 2); occupancy SHALL equal the state encoding.
REQ-021 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, and 0 whenever flush=1 or reset_n=0; it SHALL not depend on out_ready.
REQ-022 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-023 Transitions: EMPTY+in -> ONE; ONE+in+no out -> FULL; ONE+out+no in -> EMPTY; ONE+in+out -> ONE; FULL+out -> ONE; otherwise hold.
REQ-024 Latency SHALL be 1 cycle: entry accepted at edge N appears on outputs after edge N when the stage was EMPTY or draining.
REQ-025 Sustained throughput SHALL be 1 entry/cycle when in_valid=out_ready=1.
REQ-026 Order SHALL be preserved; on FULL->ONE the skid entry SHALL move to the main register at the same edge.
REQ-027 Entries SHALL never be dropped or duplicated except by flush or reset.
REQ-028 out_ctrl SHALL be all-zero whenever out_valid=0 (bubble carries no REG_WR/DIR_WB); out_do/out_dir/out_rd are don't-care but SHALL hold their last value.
REQ-029 flush=1 at an edge SHALL set state EMPTY and discard both entries, overriding any simultaneous transfer-in or transfer-out.
REQ-030 Payload fields SHALL pass unmodified, no width conversion or arithmetic.

Reset
REQ-031 reset_n=0 SHALL immediately (without clock) set state EMPTY, occupancy 0, out_valid 0, out_ctrl 0, all payload registers 0, in_ready 0.
REQ-032 After reset_n rises, in_ready SHALL be 1 from the first cycle; reset asserted mid-transfer SHALL discard all entries.

Verification
REQ-033 Reset then in_valid=1, ctrl=2'b01, do=32'hDEADBEEF, dir=32'h00000010, rd=5'd7, out_ready=1 -> next cycle out_valid=1, out_ctrl=01, out_do=DEADBEEF, out_dir=00000010, out_rd=7, occupancy=1.
REQ-034 out_ready=0, push A (rd=1) then B (rd=2) -> occupancy 2, in_ready=0; C offered is not accepted; out_ready=1 -> A, then B, then C on successive cycles.
REQ-035 Continuous stream rd=0..15 with in_valid=out_ready=1 -> one output per cycle, rd 0..15 in order, occupancy constant 1.
REQ-036 FULL with in_valid=1 and flush=1 on same edge -> next cycle occupancy 0, out_valid 0, out_ctrl 00; no entry emerges.
REQ-037 reset_n dropped between edges while FULL -> out_valid and in_ready go 0 combinationally before next edge; after release, occupancy 0.
REQ-038 Random in_valid/out_ready (10k cycles) -> scoreboard: output sequence equals accepted sequence, out_ctrl=0 whenever out_valid=0.
